// File: rtl/lsu_arb_pkg.sv
// lsu_arb_pkg: shared types for the LSU arbiter (FSM state, master index, LSU bus fields)
package lsu_arb_pkg;
  typedef enum logic {IDLE, ACCESS} state_t;
  typedef logic mst_t;
  localparam mst_t M0 = 1'b0;
  localparam mst_t M1 = 1'b1;
  typedef struct packed {
    logic        we;
    logic [2:0]  mode;
    logic [31:0] addr;
    logic [31:0] wdata;
  } lsu_bus_t;
endpackage

// File: rtl/lsu_arb_if.sv
// lsu_arb_if: one requester's req/gnt channel (req, we, mode, addr, wdata, lock -> gnt, rvalid, rdata)
interface lsu_arb_if;
  logic        req;
  logic        we;
  logic [2:0]  mode;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        lock;
  logic        gnt;
  logic        rvalid;
  logic [31:0] rdata;
  modport master (output req, we, mode, addr, wdata, lock, input gnt, rvalid, rdata);
  modport slave  (input req, we, mode, addr, wdata, lock, output gnt, rvalid, rdata);
endinterface

// File: rtl/lsu_arb_pick.sv
// lsu_arb_pick: combinational 2-way winner select (req[1:0], last_gnt, lock state -> win, vld)
module lsu_arb_pick
  import lsu_arb_pkg::*;
#(
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic [1:0] req,
  input  mst_t       last_gnt,
  input  logic       lock_vld,
  input  mst_t       lock_owner,
  input  logic       cap_hit,
  output mst_t       win,
  output logic       vld
);
  mst_t arb;
  logic own_req, oth_req;
  assign arb     = (&req) ? (FIXED_PRIO ? M0 : ~last_gnt) : (req[1] ? M1 : M0);
  assign own_req = req[lock_owner];
  assign oth_req = req[~lock_owner];
  // A live lock overrides arbitration until the cap is hit with the other master waiting.
  assign win = (lock_vld && own_req) ? ((cap_hit && oth_req) ? ~lock_owner : lock_owner) : arb;
  assign vld = |req;
endmodule

// File: rtl/lsu_arb.sv
// lsu_arb: two-master req/gnt arbiter onto one LSU port (clk_i, rst_i, m0/m1 channels, lsu_* bus); optional LSU_ARB_LOCK_EN bus locking
module lsu_arb
  import lsu_arb_pkg::*;
#(
  parameter bit          FIXED_PRIO = 1'b0,
  parameter int unsigned MAX_LOCK   = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  lsu_arb_if.slave    m0,
  lsu_arb_if.slave    m1,
  output logic        lsu_st_en,
  output logic [2:0]  lsu_datamode,
  output logic [31:0] lsu_addr,
  output logic [31:0] lsu_wdata,
  input  logic [31:0] lsu_rdata
);
  state_t   state;
  mst_t     last_gnt, cur, win, lock_owner;
  lsu_bus_t bus, sel;
  logic     vld, lock_vld, cap_hit;
  logic [1:0] req;
  assign req = {m1.req, m0.req};
  assign sel = win ? lsu_bus_t'({m1.we, m1.mode, m1.addr, m1.wdata})
                   : lsu_bus_t'({m0.we, m0.mode, m0.addr, m0.wdata});
  assign {lsu_st_en, lsu_datamode, lsu_addr, lsu_wdata} = bus;
  lsu_arb_pick #(.FIXED_PRIO(FIXED_PRIO)) u_pick (
    .req(req), .last_gnt(last_gnt), .lock_vld(lock_vld), .lock_owner(lock_owner),
    .cap_hit(cap_hit), .win(win), .vld(vld)
  );
`ifdef LSU_ARB_LOCK_EN
  localparam logic [3:0] MAX_L = 4'(MAX_LOCK);
  logic [3:0] lock_cnt;
  logic [1:0] lock_in;
  assign lock_in = {m1.lock, m0.lock};
  assign cap_hit = lock_cnt >= MAX_L;
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      lock_vld   <= 1'b0;
      lock_owner <= M0;
      lock_cnt   <= '0;
    end else if (state == IDLE) begin
      if (vld && lock_in[win]) begin
        lock_vld   <= 1'b1;
        lock_owner <= win;
        lock_cnt   <= (lock_vld && lock_owner == win) ? (cap_hit ? lock_cnt : lock_cnt + 4'd1) : 4'd1;
      end else begin
        lock_vld <= 1'b0;
        lock_cnt <= '0;
      end
    end
  end
`else
  logic unused_lock;
  assign unused_lock = m0.lock ^ m1.lock ^ (MAX_LOCK == 0);
  assign lock_vld    = 1'b0;
  assign lock_owner  = M0;
  assign cap_hit     = 1'b0;
`endif
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state     <= IDLE;
      bus       <= '0;
      last_gnt  <= M1;
      cur       <= M0;
      m0.gnt    <= 1'b0;
      m1.gnt    <= 1'b0;
      m0.rvalid <= 1'b0;
      m1.rvalid <= 1'b0;
      m0.rdata  <= '0;
      m1.rdata  <= '0;
    end else if (state == IDLE) begin
      m0.rvalid <= 1'b0;
      m1.rvalid <= 1'b0;
      if (vld) begin
        state    <= ACCESS;
        bus      <= sel;
        cur      <= win;
        last_gnt <= win;
        m0.gnt   <= win == M0;
        m1.gnt   <= win == M1;
      end
    end else begin
      state     <= IDLE;
      bus       <= '0;
      m0.gnt    <= 1'b0;
      m1.gnt    <= 1'b0;
      m0.rvalid <= cur == M0;
      m1.rvalid <= cur == M1;
      if (cur == M0) m0.rdata <= bus.we ? 32'h0 : lsu_rdata;
      else m1.rdata <= bus.we ? 32'h0 : lsu_rdata;
    end
  end
endmodule

// File: tb/tb_lsu_arb.sv
// tb_lsu_arb: directed self-checking bench for lsu_arb (round-robin and fixed-priority instances)
module tb_lsu_arb;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  int n_cmp = 0;
  int n_err = 0;
  lsu_arb_if a0 (), a1 (), b0 (), b1 ();
  logic        st_a, st_b;
  logic [2:0]  dm_a, dm_b;
  logic [31:0] ad_a, ad_b, wd_a, wd_b, rd_a;
  logic [31:0] rd_b = 32'h0;
  logic [31:0] mem [0:255];
  assign {b0.req, b0.we, b0.mode, b0.addr, b0.wdata, b0.lock} = {a0.req, a0.we, a0.mode, a0.addr, a0.wdata, a0.lock};
  assign {b1.req, b1.we, b1.mode, b1.addr, b1.wdata, b1.lock} = {a1.req, a1.we, a1.mode, a1.addr, a1.wdata, a1.lock};
  always @(posedge clk) if (st_a) mem[ad_a[15:8]] <= wd_a;
  assign rd_a = (ad_a == 32'h7800) ? 32'h0000_00A5 : mem[ad_a[15:8]];
  lsu_arb #(.FIXED_PRIO(1'b0), .MAX_LOCK(4)) u_rr (
    .clk_i(clk), .rst_i(rst), .m0(a0), .m1(a1),
    .lsu_st_en(st_a), .lsu_datamode(dm_a), .lsu_addr(ad_a), .lsu_wdata(wd_a), .lsu_rdata(rd_a)
  );
  lsu_arb #(.FIXED_PRIO(1'b1), .MAX_LOCK(4)) u_fp (
    .clk_i(clk), .rst_i(rst), .m0(b0), .m1(b1),
    .lsu_st_en(st_b), .lsu_datamode(dm_b), .lsu_addr(ad_b), .lsu_wdata(wd_b), .lsu_rdata(rd_b)
  );
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic set0(input logic r, input logic w, input logic [31:0] ad, input logic [31:0] wd, input logic lk);
    a0.req = r; a0.we = w; a0.mode = 3'd2; a0.addr = ad; a0.wdata = wd; a0.lock = lk;
  endtask
  task automatic set1(input logic r, input logic w, input logic [31:0] ad, input logic [31:0] wd, input logic lk);
    a1.req = r; a1.we = w; a1.mode = 3'd4; a1.addr = ad; a1.wdata = wd; a1.lock = lk;
  endtask
  initial begin
    set0(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    set1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    step;
    step;
    chk("rst_gnt", {a0.gnt, a1.gnt, a0.rvalid, a1.rvalid}, 32'h0);
    chk("rst_bus", {st_a, dm_a, ad_a | wd_a}, 32'h0);
    chk("rst_rdata", a0.rdata | a1.rdata, 32'h0);
    rst = 1'b0;
    // m0 store
    set0(1'b1, 1'b1, 32'h0000_2000, 32'hDEAD_BEEF, 1'b0);
    step;
    chk("st_gnt", {a0.gnt, a1.gnt}, 32'h2);
    chk("st_en", st_a, 32'h1);
    chk("st_addr", ad_a, 32'h0000_2000);
    chk("st_wdata", wd_a, 32'hDEAD_BEEF);
    chk("st_mode", dm_a, 32'h2);
    set0(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    step;
    chk("st_rvalid", {a0.rvalid, a1.rvalid, a0.gnt}, 32'h4);
    chk("st_rdata", a0.rdata, 32'h0);
    chk("st_idle_bus", {st_a, dm_a, ad_a | wd_a}, 32'h0);
    // m1 load of the stored word
    set1(1'b1, 1'b0, 32'h0000_2000, 32'h0, 1'b0);
    step;
    chk("ld_gnt", {a0.gnt, a1.gnt}, 32'h1);
    chk("ld_st_en", st_a, 32'h0);
    chk("ld_addr", ad_a, 32'h0000_2000);
    chk("ld_mode", dm_a, 32'h4);
    set1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    step;
    chk("ld_rvalid", {a0.rvalid, a1.rvalid}, 32'h1);
    chk("ld_rdata", a1.rdata, 32'hDEAD_BEEF);
    chk("ld_m0_hold", a0.rdata, 32'h0);
    // both requesting continuously: m0 wins first tie (last_gnt = m1)
    set0(1'b1, 1'b0, 32'h0000_2000, 32'h0, 1'b0);
    set1(1'b1, 1'b0, 32'h0000_2000, 32'h0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      step;
      chk($sformatf("rr_gnt%0d", i), {a0.gnt, a1.gnt}, (i % 2 == 0) ? 32'h2 : 32'h1);
      chk($sformatf("fp_gnt%0d", i), {b0.gnt, b1.gnt}, 32'h2);
      step;
      chk($sformatf("rr_dead%0d", i), {a0.gnt, a1.gnt}, 32'h0);
    end
    set0(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    // m1 reads switches
    set1(1'b1, 1'b0, 32'h0000_7800, 32'h0, 1'b0);
    step;
    chk("sw_gnt", {a0.gnt, a1.gnt}, 32'h1);
    set1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    step;
    chk("sw_rvalid", a1.rvalid, 32'h1);
    chk("sw_rdata", a1.rdata, 32'h0000_00A5);
    chk("sw_m0_hold", a0.rdata, 32'hDEAD_BEEF);
    chk("sw_idle_bus", {st_a, dm_a, ad_a | wd_a}, 32'h0);
    // reset during m0 store ACCESS
    set0(1'b1, 1'b1, 32'h0000_7000, 32'h0000_0055, 1'b0);
    step;
    chk("rs_gnt", a0.gnt, 32'h1);
    set0(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    rst = 1'b1;
    step;
    rst = 1'b0;
    chk("rs_commit", mem[8'h70], 32'h0000_0055);
    chk("rs_outs", {a0.gnt, a1.gnt, a0.rvalid, a1.rvalid, st_a, dm_a}, 32'h0);
    chk("rs_bus", ad_a | wd_a | a0.rdata | a1.rdata, 32'h0);
    step;
    chk("rs_no_rvalid", {a0.rvalid, a1.rvalid}, 32'h0);
    set1(1'b1, 1'b0, 32'h0000_7000, 32'h0, 1'b0);
    step;
    chk("rs_idle_gnt", {a0.gnt, a1.gnt}, 32'h1);
    set1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    step;
    chk("rs_readback", a1.rdata, 32'h0000_0055);
`ifdef LSU_ARB_LOCK_EN
    rst = 1'b1;
    step;
    rst = 1'b0;
    set0(1'b1, 1'b0, 32'h0000_2000, 32'h0, 1'b1);
    set1(1'b1, 1'b0, 32'h0000_2000, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      step;
      chk($sformatf("lk_gnt%0d", i), {a0.gnt, a1.gnt}, (i < 4) ? 32'h2 : 32'h1);
      step;
    end
    set0(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    set1(1'b0, 1'b0, 32'h0, 32'h0, 1'b0);
    step;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/lsu_arb.md
Name: lsu_arb

Overview:
- Two-master arbiter in front of the load/store unit. Shares one LSU port between the CPU datapath (m0) and a secondary master (m1, debug loader / DMA).
- Serialises accesses with a req/gnt handshake and registers the LSU bus fields and read data.
- Sits between the requesters and the LSU inputs (st_en, datamode, lsu_addr, lsu_i) and the LSU output (lsu_o).

Parameters:
- FIXED_PRIO, 0, 0 = round-robin; 1 = m0 always wins when both request.
- MAX_LOCK, 4, maximum consecutive locked grants to one master while the other is requesting (range 1..15).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  synchronous, active-high reset.
- m0_req / m1_req  in  1  access request; held with fields stable until gnt.
- m0_we / m1_we  in  1  1 = store, 0 = load.
- m0_mode / m1_mode  in  3  datamode, forwarded unmodified.
- m0_addr / m1_addr  in  32  byte address.
- m0_wdata / m1_wdata  in  32  store data.
- m0_lock / m1_lock  in  1  hold bus for the next access (optional feature).
- m0_gnt / m1_gnt  out  1  one-cycle pulse; access executes this cycle.
- m0_rvalid / m1_rvalid  out  1  one-cycle pulse, cycle after gnt (loads and stores).
- m0_rdata / m1_rdata  out  32  load data, valid with rvalid; 0 for stores.
- lsu_st_en  out  1  to LSU st_en.
- lsu_datamode  out  3  to LSU datamode.
- lsu_addr  out  32  to LSU lsu_addr.
- lsu_wdata  out  32  to LSU lsu_i.
- lsu_rdata  in  32  from LSU lsu_o.

Behaviour:
- FSM states: IDLE, ACCESS.
  - IDLE with any eligible req → ACCESS. Winner's we/mode/addr/wdata are registered onto lsu_* at this edge.
  - ACCESS → IDLE unconditionally; one dead cycle per access.
- Timing: req seen in IDLE at cycle t → gnt at t+1 (ACCESS, LSU driven) → rvalid/rdata at t+2.
  - Peak throughput is 1 access per 2 cycles.
  - The requester drops or updates req at the edge ending its gnt cycle. req is sampled fresh in the following IDLE.
- Store commit: the store is committed by the LSU on the edge ending ACCESS.
- Load capture: lsu_rdata is captured on the edge ending ACCESS into the granted master's rdata.
  - The other master's rdata holds its old value.
- Bus outside ACCESS: lsu_st_en = 0, lsu_addr = 0, lsu_datamode = 0, lsu_wdata = 0 (a harmless null read).
- Arbitration:
  - Single requester wins.
  - Both requesting, FIXED_PRIO = 0: the master not in last_gnt wins.
  - Both requesting, FIXED_PRIO = 1: m0 wins.
  - last_gnt updates on every grant.
- Exclusivity: gnt and rvalid are never asserted to both masters in the same cycle.
- req dropped before gnt: request withdrawn, no access. Dropping req while in ACCESS has no effect on the current access.
- Reset values (edge with rst_i = 1):
  - state = IDLE; all gnt, rvalid, lsu_* = 0; rdata = 0.
  - last_gnt = m1, so m0 wins the first tie.
  - lock_cnt = 0, lock_owner cleared.
- Reset during ACCESS: that cycle's LSU write still commits (synchronous). No rvalid is issued afterwards.

Optional Feature:
- Macro: LSU_ARB_LOCK_EN.
- Defined, lock grant: a granted master with lock = 1 becomes lock_owner. In following IDLE cycles only the owner is eligible while its req = 1.
- Defined, lock release: lock is released when the owner's req = 0 in IDLE, or lock = 0 at a grant.
- Defined, lock cap: lock_cnt counts consecutive locked grants. On reaching MAX_LOCK with the other master requesting, the lock is forcibly released and the other master wins; lock_cnt resets to 0.
- Undefined: lock inputs are ignored, no lock_owner or lock_cnt logic, pure arbitration.

Decomposition:
- Package lsu_arb_pkg:
  - state enum (IDLE, ACCESS).
  - master-index typedef (1 bit); constants M0 = 0, M1 = 1.
  - lsu bus struct (we, mode, addr, wdata).
- Sub-module lsu_arb_pick: combinational 2-way picker. Inputs: reqs, last_gnt, FIXED_PRIO, lock state. Output: winner plus valid.

Test Plan:
- Reset, then m0 store (we = 1, addr = 0x0000_2000, wdata = 0xDEAD_BEEF) → m0_gnt at t+1 with lsu_st_en = 1, lsu_addr = 0x2000. m0_rvalid at t+2, m0_rdata = 0.
- m1 load from 0x2000 after that store → lsu_st_en = 0 in ACCESS; m1_rvalid at t+2 with m1_rdata = 0xDEAD_BEEF; m0_rdata unchanged.
- Both masters request continuously, FIXED_PRIO = 0 → grants alternate m0, m1, m0, m1 every 2 cycles. FIXED_PRIO = 1 → all grants go to m0.
- Reset asserted during m0's ACCESS to LEDR 0x0000_7000 → write commits; next cycle all outputs = 0, no m0_rvalid, state = IDLE.
- LSU_ARB_LOCK_EN, MAX_LOCK = 4: m0 holds lock = 1 and req, m1 requests → m0 gets 4 consecutive grants, then m1 is granted.
- m1 reads switches at 0x0000_7800 with lsu_rdata driven to 0x0000_00A5 → m1_rdata = 0x0000_00A5 with m1_rvalid; the bus returns to zeros in IDLE.
